// File: rtl/xbar_slave_mem.sv
// rtl/xbar_slave_mem.sv - crossbar target memory with wait states and range check (optional byte enables: XBAR_SLAVE_MEM_BE_EN)
module xbar_slave_mem #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 31,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                cmd,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
`ifdef XBAR_SLAVE_MEM_BE_EN
    input  logic [DATA_W/8-1:0] be,
`endif
    output logic                ack,
    output logic                err,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state;
    logic [7:0]        cnt;
    logic              cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              acc_fire;
    logic              acc_cmd;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

`ifdef XBAR_SLAVE_MEM_BE_EN
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W/8-1:0] acc_be;
`endif

    // With zero wait states the access happens on the request edge, so the
    // access operands come straight from the bus in IDLE and from the
    // latched copies otherwise.
    always_comb begin
        acc_cmd   = cmd_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
`ifdef XBAR_SLAVE_MEM_BE_EN
        acc_be    = be_q;
`endif
        if (state == ST_IDLE) begin
            acc_cmd   = cmd;
            acc_addr  = addr;
            acc_wdata = wdata;
`ifdef XBAR_SLAVE_MEM_BE_EN
            acc_be    = be;
`endif
        end
    end

    assign acc_fire = ((state == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 8'd0));
    // Full-width compare so high address bits never alias into the array.
    assign in_range = 64'(acc_addr) < 64'(DEPTH);
    assign idx      = acc_addr[IDX_W-1:0];
    assign busy     = (state != ST_IDLE);

    // Request sequencing, wait countdown and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= acc_fire;
            err <= acc_fire && !in_range;
            if (acc_fire && !acc_cmd) begin
                rdata <= in_range ? mem[idx] : ERR_WORD;
            end
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        cmd_q   <= cmd;
                        addr_q  <= addr;
                        wdata_q <= wdata;
`ifdef XBAR_SLAVE_MEM_BE_EN
                        be_q    <= be;
`endif
                        if (WAIT_STATES == 0) begin
                            state <= ST_ACK;
                        end else begin
                            cnt   <= 8'(WAIT_STATES - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 8'd0) begin
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage write port; contents survive reset, and a reset edge cancels
    // any access that would otherwise land on it.
    always_ff @(posedge clk) begin
        if (!rst && acc_fire && acc_cmd && in_range) begin
`ifdef XBAR_SLAVE_MEM_BE_EN
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (acc_be[i]) begin
                    mem[idx][i*8 +: 8] <= acc_wdata[i*8 +: 8];
                end
            end
`else
            mem[idx] <= acc_wdata;
`endif
        end
    end

endmodule
